// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_param
//  Purpose  : Parametrised two-read / one-write register file with registered
//             reads, optional write-first bypass, optional hardwired-zero
//             register 0, per-register written-since-reset tracking and a
//             saturating count of accepted writes.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned ZERO_REG   = 0,
    parameter int unsigned BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE_EN,
    input  logic [ADDR_WIDTH-1:0] WRITE_ADDR,
    input  logic [DATA_WIDTH-1:0] WRITE_DATA,
    input  logic                  READ_EN,
    input  logic [ADDR_WIDTH-1:0] READ_ADDR_A,
    input  logic [ADDR_WIDTH-1:0] READ_ADDR_B,
    output logic [DATA_WIDTH-1:0] OUT_A,
    output logic [DATA_WIDTH-1:0] OUT_B,
    output logic                  VALID_A,
    output logic                  VALID_B,
    output logic [15:0]           WRITE_COUNT
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic        c_zero_en   = (ZERO_REG != 0);
    localparam logic        c_bypass_en = (BYPASS != 0);
    // In zero-register mode register 0 counts as written from reset onwards.
    localparam logic [DEPTH-1:0] c_valid_rst = {{(DEPTH-1){1'b0}}, c_zero_en};
    localparam logic [15:0]      c_count_max = 16'hFFFF;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [15:0]           count_q;
    logic [15:0]           count_d;
    logic [DATA_WIDTH-1:0] out_a_q, out_a_d;
    logic [DATA_WIDTH-1:0] out_b_q, out_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;
    logic                  wr_accept_d;

    // A write is accepted unless it targets the hardwired-zero register.
    always_comb begin
        wr_accept_d = WRITE_EN && !(c_zero_en && (WRITE_ADDR == '0));
        count_d     = count_q;
        if (wr_accept_d && (count_q != c_count_max)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Port A next value: zero register, then bypass, then stored contents.
    always_comb begin
        out_a_d   = mem_q[READ_ADDR_A];
        valid_a_d = valid_q[READ_ADDR_A];
        if (c_zero_en && (READ_ADDR_A == '0)) begin
            out_a_d   = '0;
            valid_a_d = 1'b1;
        end else if (c_bypass_en && wr_accept_d && (WRITE_ADDR == READ_ADDR_A)) begin
            out_a_d   = WRITE_DATA;
            valid_a_d = 1'b1;
        end
    end

    // Port B next value: same priority as port A.
    always_comb begin
        out_b_d   = mem_q[READ_ADDR_B];
        valid_b_d = valid_q[READ_ADDR_B];
        if (c_zero_en && (READ_ADDR_B == '0)) begin
            out_b_d   = '0;
            valid_b_d = 1'b1;
        end else if (c_bypass_en && wr_accept_d && (WRITE_ADDR == READ_ADDR_B)) begin
            out_b_d   = WRITE_DATA;
            valid_b_d = 1'b1;
        end
    end

    // Storage array, valid bits and write counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= c_valid_rst;
            count_q <= '0;
        end else begin
            if (wr_accept_d) begin
                mem_q[WRITE_ADDR]   <= WRITE_DATA;
                valid_q[WRITE_ADDR] <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    // Registered read outputs, held while READ_EN is low.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            out_a_q   <= '0;
            out_b_q   <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else if (READ_EN) begin
            out_a_q   <= out_a_d;
            out_b_q   <= out_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    assign OUT_A       = out_a_q;
    assign OUT_B       = out_b_q;
    assign VALID_A     = valid_a_q;
    assign VALID_B     = valid_b_q;
    assign WRITE_COUNT = count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_file_param
//  Purpose  : Directed self-checking bench for reg_file_param in four
//             parameter configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Shared stimulus for the three 8-bit instances.
    logic       we = 1'b0, re = 1'b0;
    logic [2:0] wa = '0, ra = '0, rb = '0;
    logic [7:0] wd = '0;
    // Stimulus for the 16x32 instance.
    logic        we16 = 1'b0, re16 = 1'b0;
    logic [4:0]  wa16 = '0, ra16 = '0, rb16 = '0;
    logic [15:0] wd16 = '0;

    logic [7:0]  oa_d, ob_d, oa_n, ob_n, oa_z, ob_z;
    logic        va_d, vb_d, va_n, vb_n, va_z, vb_z;
    logic [15:0] cnt_d, cnt_n, cnt_z, cnt_w;
    logic [15:0] oa_w, ob_w;
    logic        va_w, vb_w;

    int vectors = 0;
    int miscompares = 0;

    // Default: bypass on, no zero register.
    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(1)) u_def (
        .CLK(clk), .RESET(rst), .WRITE_EN(we), .WRITE_ADDR(wa), .WRITE_DATA(wd),
        .READ_EN(re), .READ_ADDR_A(ra), .READ_ADDR_B(rb),
        .OUT_A(oa_d), .OUT_B(ob_d), .VALID_A(va_d), .VALID_B(vb_d), .WRITE_COUNT(cnt_d));
    // No bypass.
    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0), .BYPASS(0)) u_nob (
        .CLK(clk), .RESET(rst), .WRITE_EN(we), .WRITE_ADDR(wa), .WRITE_DATA(wd),
        .READ_EN(re), .READ_ADDR_A(ra), .READ_ADDR_B(rb),
        .OUT_A(oa_n), .OUT_B(ob_n), .VALID_A(va_n), .VALID_B(vb_n), .WRITE_COUNT(cnt_n));
    // Hardwired zero register.
    reg_file_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1), .BYPASS(1)) u_zr (
        .CLK(clk), .RESET(rst), .WRITE_EN(we), .WRITE_ADDR(wa), .WRITE_DATA(wd),
        .READ_EN(re), .READ_ADDR_A(ra), .READ_ADDR_B(rb),
        .OUT_A(oa_z), .OUT_B(ob_z), .VALID_A(va_z), .VALID_B(vb_z), .WRITE_COUNT(cnt_z));
    // Wide and deep.
    reg_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(1)) u_wide (
        .CLK(clk), .RESET(rst), .WRITE_EN(we16), .WRITE_ADDR(wa16), .WRITE_DATA(wd16),
        .READ_EN(re16), .READ_ADDR_A(ra16), .READ_ADDR_B(rb16),
        .OUT_A(oa_w), .OUT_B(ob_w), .VALID_A(va_w), .VALID_B(vb_w), .WRITE_COUNT(cnt_w));

    // Advance one rising edge; stimulus changes and checks land 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++; if (oa_d !== 8'h00) begin miscompares++; $display("FAIL rst_init_oa: got %h exp %h", oa_d, 8'h00); end
        vectors++; if (vb_z !== 1'b0) begin miscompares++; $display("FAIL rst_init_vb_z: got %b exp %b", vb_z, 1'b0); end
        vectors++; if (cnt_d !== 16'h0000) begin miscompares++; $display("FAIL rst_init_cnt: got %h exp %h", cnt_d, 16'h0000); end
        rst = 1'b0;
        we = 1'b1; wa = 3'd3; wd = 8'h5A;
        tick();
        we = 1'b0; re = 1'b1; ra = 3'd3; rb = 3'd3;
        tick();
        vectors++; if (oa_d !== 8'h5A) begin miscompares++; $display("FAIL preload_r3: got %h exp %h", oa_d, 8'h5A); end
        re = 1'b0;
        #3 rst = 1'b1;
        #1;
        vectors++; if (oa_d !== 8'h00) begin miscompares++; $display("FAIL async_rst_oa: got %h exp %h", oa_d, 8'h00); end
        vectors++; if (ob_d !== 8'h00) begin miscompares++; $display("FAIL async_rst_ob: got %h exp %h", ob_d, 8'h00); end
        vectors++; if (cnt_d !== 16'h0000) begin miscompares++; $display("FAIL async_rst_cnt: got %h exp %h", cnt_d, 16'h0000); end
        #1 rst = 1'b0;
        re = 1'b1; ra = 3'd3;
        tick();
        vectors++; if (oa_d !== 8'h00) begin miscompares++; $display("FAIL r3_after_rst: got %h exp %h", oa_d, 8'h00); end
        vectors++; if (va_d !== 1'b0) begin miscompares++; $display("FAIL r3_valid_after_rst: got %b exp %b", va_d, 1'b0); end
        re = 1'b0;
    endtask

    task automatic test_write_read();
        we = 1'b1; wa = 3'd0; wd = 8'h04;
        tick();
        wa = 3'd1; wd = 8'h02;
        tick();
        we = 1'b0; re = 1'b1; ra = 3'd0; rb = 3'd1;
        tick();
        vectors++; if (oa_d !== 8'h04) begin miscompares++; $display("FAIL wr_oa: got %h exp %h", oa_d, 8'h04); end
        vectors++; if (ob_d !== 8'h02) begin miscompares++; $display("FAIL wr_ob: got %h exp %h", ob_d, 8'h02); end
        vectors++; if ({va_d, vb_d} !== 2'b11) begin miscompares++; $display("FAIL wr_valid: got %b exp %b", {va_d, vb_d}, 2'b11); end
        vectors++; if (cnt_d !== 16'd2) begin miscompares++; $display("FAIL wr_cnt: got %h exp %h", cnt_d, 16'd2); end
        vectors++; if (oa_n !== 8'h04) begin miscompares++; $display("FAIL wr_oa_nob: got %h exp %h", oa_n, 8'h04); end
        vectors++; if (oa_z !== 8'h00) begin miscompares++; $display("FAIL wr_oa_zr: got %h exp %h", oa_z, 8'h00); end
        vectors++; if (va_z !== 1'b1) begin miscompares++; $display("FAIL wr_va_zr: got %b exp %b", va_z, 1'b1); end
        vectors++; if (ob_z !== 8'h02) begin miscompares++; $display("FAIL wr_ob_zr: got %h exp %h", ob_z, 8'h02); end
        vectors++; if (cnt_z !== 16'd1) begin miscompares++; $display("FAIL wr_cnt_zr: got %h exp %h", cnt_z, 16'd1); end
        re = 1'b0;
    endtask

    task automatic test_bypass();
        we = 1'b1; wa = 3'd5; wd = 8'h33;
        tick();
        wd = 8'h0A; re = 1'b1; ra = 3'd5; rb = 3'd5;
        tick();
        vectors++; if (oa_d !== 8'h0A) begin miscompares++; $display("FAIL byp_oa: got %h exp %h", oa_d, 8'h0A); end
        vectors++; if (ob_d !== 8'h0A) begin miscompares++; $display("FAIL byp_ob: got %h exp %h", ob_d, 8'h0A); end
        vectors++; if (oa_n !== 8'h33) begin miscompares++; $display("FAIL nobyp_old: got %h exp %h", oa_n, 8'h33); end
        we = 1'b0;
        tick();
        vectors++; if (oa_n !== 8'h0A) begin miscompares++; $display("FAIL nobyp_new: got %h exp %h", oa_n, 8'h0A); end
        we = 1'b1; wa = 3'd6; wd = 8'h77; ra = 3'd6; rb = 3'd5;
        tick();
        vectors++; if ({va_d, oa_d} !== {1'b1, 8'h77}) begin miscompares++; $display("FAIL byp_unwritten: got %b/%h exp 1/77", va_d, oa_d); end
        vectors++; if ({va_n, oa_n} !== {1'b0, 8'h00}) begin miscompares++; $display("FAIL nobyp_unwritten: got %b/%h exp 0/00", va_n, oa_n); end
        vectors++; if (ob_d !== 8'h0A) begin miscompares++; $display("FAIL byp_other_port: got %h exp %h", ob_d, 8'h0A); end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wa = 3'd0; wd = 8'hFF; re = 1'b1; ra = 3'd0; rb = 3'd1;
        tick();
        vectors++; if (oa_z !== 8'h00) begin miscompares++; $display("FAIL zr_bypass_blocked: got %h exp %h", oa_z, 8'h00); end
        we = 1'b0; rb = 3'd0;
        tick();
        vectors++; if ({va_z, oa_z} !== {1'b1, 8'h00}) begin miscompares++; $display("FAIL zr_read: got %b/%h exp 1/00", va_z, oa_z); end
        vectors++; if (cnt_z !== 16'd4) begin miscompares++; $display("FAIL zr_cnt: got %h exp %h", cnt_z, 16'd4); end
        vectors++; if (oa_d !== 8'hFF) begin miscompares++; $display("FAIL nozr_read: got %h exp %h", oa_d, 8'hFF); end
        vectors++; if (cnt_d !== 16'd6) begin miscompares++; $display("FAIL nozr_cnt: got %h exp %h", cnt_d, 16'd6); end
        re = 1'b0;
    endtask

    task automatic test_hold();
        re = 1'b1; ra = 3'd1; rb = 3'd1;
        tick();
        vectors++; if (ob_d !== 8'h02) begin miscompares++; $display("FAIL hold_pre: got %h exp %h", ob_d, 8'h02); end
        re = 1'b0; we = 1'b1; wa = 3'd1; wd = 8'h99; rb = 3'd6;
        tick();
        vectors++; if ({vb_d, ob_d} !== {1'b1, 8'h02}) begin miscompares++; $display("FAIL hold_ob: got %b/%h exp 1/02", vb_d, ob_d); end
        vectors++; if (ob_n !== 8'h02) begin miscompares++; $display("FAIL hold_ob_nob: got %h exp %h", ob_n, 8'h02); end
        we = 1'b0; re = 1'b1; rb = 3'd1;
        tick();
        vectors++; if (ob_d !== 8'h99) begin miscompares++; $display("FAIL hold_release: got %h exp %h", ob_d, 8'h99); end
        re = 1'b0;
    endtask

    task automatic test_wide();
        we16 = 1'b1; wa16 = 5'd31; wd16 = 16'hBEEF;
        tick();
        we16 = 1'b0; re16 = 1'b1; ra16 = 5'd31; rb16 = 5'd30;
        tick();
        vectors++; if ({va_w, oa_w} !== {1'b1, 16'hBEEF}) begin miscompares++; $display("FAIL wide_r31: got %b/%h exp 1/beef", va_w, oa_w); end
        vectors++; if ({vb_w, ob_w} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL wide_r30: got %b/%h exp 0/0000", vb_w, ob_w); end
        vectors++; if (cnt_w !== 16'd1) begin miscompares++; $display("FAIL wide_cnt: got %h exp %h", cnt_w, 16'd1); end
        re16 = 1'b0;
    endtask

    task automatic test_saturation();
        vectors++; if (cnt_d !== 16'd7) begin miscompares++; $display("FAIL sat_start: got %h exp %h", cnt_d, 16'd7); end
        we = 1'b1; wa = 3'd2; wd = 8'h11;
        for (int i = 0; i < 65527; i++) tick();
        vectors++; if (cnt_d !== 16'hFFFE) begin miscompares++; $display("FAIL sat_below: got %h exp %h", cnt_d, 16'hFFFE); end
        tick();
        vectors++; if (cnt_d !== 16'hFFFF) begin miscompares++; $display("FAIL sat_reach: got %h exp %h", cnt_d, 16'hFFFF); end
        for (int i = 0; i < 10; i++) tick();
        vectors++; if (cnt_d !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stay: got %h exp %h", cnt_d, 16'hFFFF); end
        vectors++; if (cnt_z !== 16'hFFFF) begin miscompares++; $display("FAIL sat_stay_zr: got %h exp %h", cnt_z, 16'hFFFF); end
        we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_hold();
        test_wide();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the team's 8x8 two-read/one-write register file for the CPU datapath.
- Adds generic width and depth, a single clean posedge clock domain, registered reads with write-first bypass, an optional hardwired-zero register, and per-register "written since reset" valid tracking.
- Sits between instruction decode (addresses) and the ALU (operands). The writeback stage drives the write port.

Parameters:
DATA_WIDTH, 8, bits per register
ADDR_WIDTH, 3, address bits; DEPTH = 2**ADDR_WIDTH registers
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read; 0 = old contents returned

Ports:
CLK  input  1  clock; all state updates on rising edge
RESET  input  1  asynchronous, active-high reset
WRITE_EN  input  1  write strobe, sampled at posedge CLK
WRITE_ADDR  input  ADDR_WIDTH  destination register
WRITE_DATA  input  DATA_WIDTH  value to write
READ_EN  input  1  1 = update read outputs this edge; 0 = hold
READ_ADDR_A  input  ADDR_WIDTH  port A source register
READ_ADDR_B  input  ADDR_WIDTH  port B source register
OUT_A  output  DATA_WIDTH  registered port A data
OUT_B  output  DATA_WIDTH  registered port B data
VALID_A  output  1  registered: port A register written since reset
VALID_B  output  1  registered: port B register written since reset
WRITE_COUNT  output  16  number of accepted writes since reset; saturates at 16'hFFFF

Behaviour:
- Reset (RESET high, asynchronous, no clock needed):
  - All DEPTH registers = 0; all valid bits = 0.
  - OUT_A = OUT_B = 0; VALID_A = VALID_B = 0; WRITE_COUNT = 0.
  - While RESET is high, writes and reads are ignored.
  - First active edge is the first rising CLK with RESET low.
- Write, on posedge CLK with WRITE_EN=1:
  - mem[WRITE_ADDR] <= WRITE_DATA; valid[WRITE_ADDR] <= 1.
  - Accepted writes increment WRITE_COUNT by 1, saturating at 16'hFFFF.
  - WRITE_EN=0: no state change.
- Zero register, ZERO_REG=1:
  - A write to address 0 is discarded and is not counted.
  - valid[0] stays 1 permanently (reset value 1 in this mode).
  - Reads of address 0 return 0.
- Read, on posedge CLK with READ_EN=1, per port X in {A,B}:
  - If ZERO_REG=1 and READ_ADDR_X=0: OUT_X <= 0, VALID_X <= 1.
  - Else if BYPASS=1, WRITE_EN=1 and WRITE_ADDR=READ_ADDR_X (and the write is not a discarded zero-reg write): OUT_X <= WRITE_DATA, VALID_X <= 1.
  - Else: OUT_X <= mem[READ_ADDR_X] (pre-edge contents), VALID_X <= valid[READ_ADDR_X].
  - READ_EN=0: OUT_X and VALID_X hold their values.
- Read latency: 1 cycle. Address presented before edge N; data on outputs after edge N.
- With BYPASS=0, a same-cycle read returns the old value. The new value is visible one edge later.
- Both ports may address the same register and return identical data.
- Reset mid-operation: RESET asserting between edges clears everything immediately. A write pending on the same cycle is lost.
- Addresses are always in range (DEPTH = 2**ADDR_WIDTH), so there is no out-of-range case.

Test Plan:
- Reset: preload r3=8'h5A, pulse RESET between clock edges -> OUT_A, OUT_B, WRITE_COUNT go to 0 without a clock edge; reading r3 afterwards gives OUT_A=8'h00, VALID_A=0.
- Write/read latency: write r0=8'h04, then r1=8'h02 on consecutive edges; then READ_ADDR_A=0, READ_ADDR_B=1, READ_EN=1 -> one edge later OUT_A=8'h04, OUT_B=8'h02, VALID_A=VALID_B=1, WRITE_COUNT=2.
- Bypass: same edge WRITE_EN=1, WRITE_ADDR=5, WRITE_DATA=8'h0A, READ_ADDR_A=5 -> BYPASS=1 gives OUT_A=8'h0A. BYPASS=0 gives OUT_A = previous r5, and 8'h0A on the next read.
- Zero register (ZERO_REG=1): write 8'hFF to r0 -> WRITE_COUNT unchanged, read r0 gives OUT_A=8'h00, VALID_A=1. The same test with ZERO_REG=0 reads 8'hFF.
- Hold and parameters: READ_EN=0 while r1 changes -> OUT_B holds the old value. Re-run write/read with DATA_WIDTH=16, ADDR_WIDTH=5: write r31=16'hBEEF -> reads back 16'hBEEF; unwritten r30 gives VALID=0.
- Saturation: force 65537 accepted writes -> WRITE_COUNT=16'hFFFF and it stays there.
